// File: rtl/car_alarm_pkg.sv
// Shared definitions for the car alarm controller: state codes shown on the
// debug display, countdown width and the default delay times in seconds.
package car_alarm_pkg;

  localparam int STATE_W   = 3;
  localparam int TIMER_W   = 4;
  localparam int TIMER_MAX = (1 << TIMER_W) - 1;

  // Default delays, in seconds
  localparam int T_ARM_DELAY_DEF       = 6;
  localparam int T_DRIVER_DELAY_DEF    = 8;
  localparam int T_PASSENGER_DELAY_DEF = 15;
  localparam int T_ALARM_ON_DEF        = 10;

  // State codes; the numeric values are what the debug display shows
  typedef enum logic [STATE_W-1:0] {
    ST_ARMED           = 3'd0,
    ST_TRIGGERED       = 3'd1,
    ST_SOUND_ALARM     = 3'd2,
    ST_DISARMED        = 3'd3,
    ST_WAIT_DOOR_OPEN  = 3'd4,
    ST_WAIT_DOOR_CLOSE = 3'd5,
    ST_ARM_DELAY       = 3'd6
  } alarm_state_e;

  // A delay fits the countdown only if it is representable in TIMER_W bits
  function automatic logic delay_fits(input int secs);
    return (secs >= 0) && (secs <= TIMER_MAX);
  endfunction

  // Narrow a (checked) delay in seconds to the countdown load width
  function automatic logic [TIMER_W-1:0] to_timer_val(input int secs);
    return secs[TIMER_W-1:0];
  endfunction

endpackage

// File: rtl/alarm_timer.sv
// Seconds countdown used by the car alarm controller. A load sets the count;
// each one_hz_enable strobe removes one second; expired pulses for one cycle
// when the last second of a loaded countdown elapses. A load of 0 or 1 both
// expire on the first strobe after the load. An idle timer never fires.
module alarm_timer
  import car_alarm_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [TIMER_W-1:0] value,
  input  logic               one_hz_enable,
  output logic               expired
);

  logic [TIMER_W-1:0] count;
  logic               running;

  // Countdown register: a load beats a coincident strobe, and the expiry
  // pulse is registered so it lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      running <= 1'b0;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (start) begin
        count   <= value;
        running <= 1'b1;
      end else if (one_hz_enable && running) begin
        if (count < TIMER_W'(2)) begin
          count   <= '0;
          running <= 1'b0;
          expired <= 1'b1;
        end else begin
          count <= count - TIMER_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/car_alarm_fsm.sv
// Car alarm controller. Ignition always disarms; leaving the car (driver door
// open then all doors shut) re-arms after a delay; opening a door while armed
// starts an entry countdown that ends in the siren unless ignition comes on.
// Optional build macro CAR_ALARM_BLINK_EN: the armed LED blinks at 0.5 Hz
// (toggles on every one_hz_enable) instead of being steadily lit.
module car_alarm_fsm
  import car_alarm_pkg::*;
#(
  parameter int T_ARM_DELAY       = T_ARM_DELAY_DEF,
  parameter int T_DRIVER_DELAY    = T_DRIVER_DELAY_DEF,
  parameter int T_PASSENGER_DELAY = T_PASSENGER_DELAY_DEF,
  parameter int T_ALARM_ON        = T_ALARM_ON_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               one_hz_enable,
  input  logic               ignition,
  input  logic               driver_door,
  input  logic               passenger_door,
  output logic               status_indicator,
  output logic               siren,
  output logic [STATE_W-1:0] state
);

  // Delays must fit the 4-bit countdown; reject bad overrides at elaboration.
  if (!delay_fits(T_ARM_DELAY)) begin : g_bad_arm_delay
    $error("car_alarm_fsm: T_ARM_DELAY=%0d does not fit the 4-bit timer", T_ARM_DELAY);
  end
  if (!delay_fits(T_DRIVER_DELAY)) begin : g_bad_driver_delay
    $error("car_alarm_fsm: T_DRIVER_DELAY=%0d does not fit the 4-bit timer", T_DRIVER_DELAY);
  end
  if (!delay_fits(T_PASSENGER_DELAY)) begin : g_bad_passenger_delay
    $error("car_alarm_fsm: T_PASSENGER_DELAY=%0d does not fit the 4-bit timer", T_PASSENGER_DELAY);
  end
  if (!delay_fits(T_ALARM_ON)) begin : g_bad_alarm_on
    $error("car_alarm_fsm: T_ALARM_ON=%0d does not fit the 4-bit timer", T_ALARM_ON);
  end

  localparam logic [TIMER_W-1:0] ARM_V       = to_timer_val(T_ARM_DELAY);
  localparam logic [TIMER_W-1:0] DRIVER_V    = to_timer_val(T_DRIVER_DELAY);
  localparam logic [TIMER_W-1:0] PASSENGER_V = to_timer_val(T_PASSENGER_DELAY);
  localparam logic [TIMER_W-1:0] ALARM_V     = to_timer_val(T_ALARM_ON);

  alarm_state_e       state_q;
  alarm_state_e       state_d;
  logic               tmr_start;
  logic [TIMER_W-1:0] tmr_value;
  logic               tmr_expired;
  logic               any_door;
  logic               led_q;
  logic               stay_armed;

  assign any_door   = driver_door | passenger_door;
  assign stay_armed = (state_q == ST_ARMED) && (state_d == ST_ARMED);

  alarm_timer u_timer (
    .clk           (clk),
    .reset         (reset),
    .start         (tmr_start),
    .value         (tmr_value),
    .one_hz_enable (one_hz_enable),
    .expired       (tmr_expired)
  );

  // State register; reset lands in ARMED.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ARMED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and countdown loads. Ignition overrides everything, including
  // any load. Stale expiry pulses from an abandoned countdown are harmless:
  // only TRIGGERED, SOUND_ALARM and ARM_DELAY look at expiry, and each of
  // those is entered together with a fresh load.
  always_comb begin
    state_d   = state_q;
    tmr_start = 1'b0;
    tmr_value = '0;
    if (ignition) begin
      state_d = ST_DISARMED;
    end else begin
      case (state_q)
        ST_ARMED: begin
          // Driver delay wins when both doors open together
          if (driver_door) begin
            state_d   = ST_TRIGGERED;
            tmr_start = 1'b1;
            tmr_value = DRIVER_V;
          end else if (passenger_door) begin
            state_d   = ST_TRIGGERED;
            tmr_start = 1'b1;
            tmr_value = PASSENGER_V;
          end
        end
        ST_TRIGGERED: begin
          // Closing the door again does not cancel the entry countdown
          if (tmr_expired) begin
            state_d   = ST_SOUND_ALARM;
            tmr_start = 1'b1;
            tmr_value = ALARM_V;
          end
        end
        ST_SOUND_ALARM: begin
          // An open door keeps the siren time topped up
          if (any_door) begin
            tmr_start = 1'b1;
            tmr_value = ALARM_V;
          end else if (tmr_expired) begin
            state_d = ST_ARMED;
          end
        end
        ST_DISARMED: begin
          state_d = ST_WAIT_DOOR_OPEN;
        end
        ST_WAIT_DOOR_OPEN: begin
          if (driver_door) begin
            state_d = ST_WAIT_DOOR_CLOSE;
          end
        end
        ST_WAIT_DOOR_CLOSE: begin
          if (!any_door) begin
            state_d   = ST_ARM_DELAY;
            tmr_start = 1'b1;
            tmr_value = ARM_V;
          end
        end
        ST_ARM_DELAY: begin
          if (any_door) begin
            state_d = ST_WAIT_DOOR_CLOSE;
          end else if (tmr_expired) begin
            state_d = ST_ARMED;
          end
        end
        default: begin
          state_d = ST_ARMED;
        end
      endcase
    end
  end

`ifdef CAR_ALARM_BLINK_EN
  // Armed LED blinks: starts dark on entry, toggles on each second strobe,
  // and goes dark in the same cycle the state leaves ARMED.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= 1'b0;
    end else if (stay_armed) begin
      led_q <= led_q ^ one_hz_enable;
    end else begin
      led_q <= 1'b0;
    end
  end
`else
  // Armed LED is steady: lit from the cycle after entering ARMED, dark in the
  // same cycle the state leaves ARMED.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= 1'b0;
    end else begin
      led_q <= stay_armed;
    end
  end
`endif

  assign status_indicator = led_q;
  assign siren            = (state_q == ST_SOUND_ALARM);
  assign state            = state_q;

endmodule

// File: doc/car_alarm_fsm.md
CAR_ALARM_FSM -- requirements
Module: car_alarm_fsm

Interface
REQ-001 Parameter T_ARM_DELAY, default 6: seconds from the driver door closing (ignition off) until the system re-arms.
REQ-002 Parameter T_DRIVER_DELAY, default 8: seconds of countdown after the driver door opens while armed.
REQ-003 Parameter T_PASSENGER_DELAY, default 15: seconds of countdown after a passenger door opens while armed.
REQ-004 Parameter T_ALARM_ON, default 10: seconds the siren persists after all doors are closed.
REQ-005 clk  input  1  system clock; single clock domain.
REQ-006 reset  input  1  reset; synchronous, active-high.
REQ-007 one_hz_enable  input  1  one-cycle strobe, once per second.
REQ-008 ignition  input  1  ignition switch; 1 = on.
REQ-009 driver_door  input  1  driver door switch; 1 = open.
REQ-010 passenger_door  input  1  passenger door switch; 1 = open.
REQ-011 status_indicator  output  1  armed LED.
REQ-012 siren  output  1  siren enable.
REQ-013 state  output  3  current FSM state code, for debug display.

Function
REQ-014 States SHALL be ARMED, TRIGGERED, SOUND_ALARM, DISARMED, WAIT_DOOR_OPEN, WAIT_DOOR_CLOSE and ARM_DELAY; all transitions are registered, so outputs change one cycle after the causing input.
REQ-015 ignition=1 SHALL force DISARMED from every state, and that transition SHALL take priority over all others.
REQ-016 ARMED: driver_door=1 -> TRIGGERED, with the timer loaded with T_DRIVER_DELAY; otherwise passenger_door=1 -> TRIGGERED, with the timer loaded with T_PASSENGER_DELAY; if both doors open in the same cycle, the driver delay applies.
REQ-017 TRIGGERED: timer expiry -> SOUND_ALARM; closing the doors SHALL NOT cancel the countdown.
REQ-018 SOUND_ALARM: siren=1; while any door is open the timer is held at T_ALARM_ON; once all doors are closed the timer counts down; expiry -> ARMED with siren=0; a door reopening before expiry reloads the timer.
REQ-019 DISARMED: ignition=0 -> WAIT_DOOR_OPEN.
REQ-020 WAIT_DOOR_OPEN: driver_door=1 -> WAIT_DOOR_CLOSE.
REQ-021 WAIT_DOOR_CLOSE: both doors closed -> ARM_DELAY, with the timer loaded with T_ARM_DELAY.
REQ-022 ARM_DELAY: any door open -> WAIT_DOOR_CLOSE; timer expiry -> ARMED.
REQ-023 Timer: 4-bit down-counter; start loads the value; decrements only on one_hz_enable; emits expired for exactly one cycle when the count reaches 0 on a tick.
REQ-024 If timer start and one_hz_enable occur in the same cycle, start SHALL win and no decrement SHALL occur.
REQ-025 A load value of 0 SHALL produce expired on the next one_hz_enable.
REQ-026 Countdown latency for load value N SHALL be exactly N ticks.
REQ-027 Parameter values greater than 15 are illegal; the implementation SHALL flag them with an elaboration-time check.
REQ-028 siren SHALL be 1 only in SOUND_ALARM.
REQ-029 status_indicator SHALL be 0 in all states except ARMED.

Reset
REQ-030 Reset SHALL force state=ARMED, timer count=0, expired=0, siren=0 and status_indicator=0 on the next rising clock edge.
REQ-031 Reset asserted mid-countdown or during SOUND_ALARM SHALL abort the countdown immediately and SHALL NOT produce a spurious expired pulse.

Configuration
REQ-032 With CAR_ALARM_BLINK_EN defined: in ARMED, status_indicator SHALL toggle on each one_hz_enable, starting at 0 on entry to ARMED.
REQ-033 Without CAR_ALARM_BLINK_EN: in ARMED, status_indicator SHALL be a steady 1 from the cycle after entry.

Structure
REQ-034 Package car_alarm_pkg SHALL hold the state encoding constants and the default time constants.
REQ-035 The countdown SHALL be a sub-module, alarm_timer (inputs: clk, reset, start, value[3:0], one_hz_enable; output: expired), instantiated once.

Verification
REQ-036 Reset, then driver_door=1 for one cycle, then 8 ticks -> state TRIGGERED; siren=1 exactly after the 8th tick.
REQ-037 ARMED, passenger_door=1, ignition=1 after 5 ticks -> DISARMED; siren never asserts.
REQ-038 SOUND_ALARM with door held open for 20 ticks, then closed -> siren=1 throughout, and drops exactly 10 ticks after the close; state then reads ARMED.
REQ-039 DISARMED, ignition=0, driver door opened then closed, passenger door opened at tick 3 of ARM_DELAY then closed -> WAIT_DOOR_CLOSE, then ARM_DELAY restarts; ARMED after 6 full ticks.
REQ-040 Timer start coincident with one_hz_enable, value=2 -> expired on the 2nd subsequent tick, not the 1st.
REQ-041 Reset during TRIGGERED at count 3 -> ARMED; no siren on later ticks; blink behaviour checked with and without CAR_ALARM_BLINK_EN.
